// File: rtl/cache_data_ctl.sv
`timescale 1ns/1ps
// cache_data_ctl: direct-mapped, write-back, write-allocate data cache.
// 16 lines x 4 words. On a hit it returns the addressed word and byte. On a miss it
// writes back a dirty victim, then refills the line from a block memory with
// single-cycle read latency.
// Optional feature macro: CACHE_BYTE_OUT_EN. When it is defined, byte_out carries the
// addressed byte. When it is undefined, byte_out is constant 0.
// rst_n is an asynchronous reset and asserts HIGH, despite its name.
module cache_data_ctl #(
    parameter int PA_WIDTH  = 16,
    parameter int WRD_WIDTH = 32,
    parameter int BYTE      = 8,
    parameter int BLK_WIDTH = 128,
    parameter int NUM_LINES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PA_WIDTH-1:0]  addr,
    input  logic [WRD_WIDTH-1:0] data_wr,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [BLK_WIDTH-1:0] mem_rd_blk,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_blk,
    output logic                 hit,
    output logic [WRD_WIDTH-1:0] word_out,
    output logic [BYTE-1:0]      byte_out
);
    localparam int WORDS  = BLK_WIDTH / WRD_WIDTH;
    localparam int BYTES  = WRD_WIDTH / BYTE;
    localparam int BSEL_W = $clog2(BYTES);
    localparam int WSEL_W = $clog2(WORDS);
    localparam int OFF_W  = BSEL_W + WSEL_W;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = PA_WIDTH - IDX_W - OFF_W;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL} state_t;
    state_t state_reg, state_next;

    // Latched request: the requester's inputs are not looked at again after IDLE.
    logic [PA_WIDTH-1:0]  req_addr_reg;
    logic [WRD_WIDTH-1:0] req_data_reg;
    logic                 req_wr_reg;

    // Line state. valid/dirty have a reset; tags and data do not.
    logic [NUM_LINES-1:0] valid_reg;
    logic [NUM_LINES-1:0] dirty_reg;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [BLK_WIDTH-1:0] data_mem [NUM_LINES];

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [WSEL_W-1:0]    req_word;
    logic [TAG_W-1:0]     line_tag;
    logic [BLK_WIDTH-1:0] line_data;
    logic [BLK_WIDTH-1:0] line_merged;
    logic [WRD_WIDTH-1:0] line_words [WORDS];
    logic [WRD_WIDTH-1:0] line_word;
    logic [WRD_WIDTH-1:0] new_word;
    logic [BYTE-1:0]      byte_next;
    logic                 line_hit;
    logic                 line_dirty;

    assign req_tag    = req_addr_reg[PA_WIDTH-1 -: TAG_W];
    assign req_idx    = req_addr_reg[OFF_W +: IDX_W];
    assign req_word   = req_addr_reg[BSEL_W +: WSEL_W];
    assign line_tag   = tag_mem[req_idx];
    assign line_data  = data_mem[req_idx];
    assign line_hit   = valid_reg[req_idx] && (line_tag == req_tag);
    assign line_dirty = valid_reg[req_idx] && dirty_reg[req_idx];

    // Split the selected line into words and build the write-merged copy of the line.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign line_words[gi] = line_data[gi*WRD_WIDTH +: WRD_WIDTH];
            assign line_merged[gi*WRD_WIDTH +: WRD_WIDTH] =
                (req_word == WSEL_W'(gi)) ? req_data_reg : line_words[gi];
        end
    endgenerate

    assign line_word = line_words[req_word];
    assign new_word  = req_wr_reg ? req_data_reg : line_word;

`ifdef CACHE_BYTE_OUT_EN
    logic [BYTE-1:0] new_bytes [BYTES];
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
            assign new_bytes[gi] = new_word[gi*BYTE +: BYTE];
        end
    endgenerate
    assign byte_next = new_bytes[req_addr_reg[BSEL_W-1:0]];
`else
    logic byte_sel_unused;
    assign byte_next       = '0;
    assign byte_sel_unused = &{1'b0, req_addr_reg[BSEL_W-1:0]};
`endif

    // Next-state logic. A miss always ends by re-entering COMPARE, which then hits.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (rd_en || wr_en) state_next = COMPARE;
            COMPARE: begin
                if (line_hit)        state_next = IDLE;
                else if (line_dirty) state_next = WRITEBACK;
                else                 state_next = ALLOCATE;
            end
            WRITEBACK: state_next = ALLOCATE;
            ALLOCATE:  state_next = FILL;
            FILL:      state_next = COMPARE;
            default:   state_next = IDLE;
        endcase
    end

    // State, request latch, line flags and registered outputs. The memory strobes are
    // decoded from state_next, so they are high exactly while in WRITEBACK or ALLOCATE.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg    <= IDLE;
            req_addr_reg <= '0;
            req_data_reg <= '0;
            req_wr_reg   <= 1'b0;
            valid_reg    <= '0;
            dirty_reg    <= '0;
            hit          <= 1'b0;
            word_out     <= '0;
            byte_out     <= '0;
            mem_addr     <= '0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_wr_blk   <= '0;
        end else begin
            state_reg  <= state_next;
            hit        <= 1'b0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wr_blk <= '0;
            if (state_reg == IDLE && (rd_en || wr_en)) begin
                req_addr_reg <= addr;
                req_data_reg <= data_wr;
                req_wr_reg   <= wr_en;
            end
            if (state_reg == COMPARE && line_hit) begin
                hit      <= 1'b1;
                word_out <= new_word;
                byte_out <= byte_next;
                if (req_wr_reg) dirty_reg[req_idx] <= 1'b1;
            end
            if (state_reg == FILL) begin
                valid_reg[req_idx] <= 1'b1;
                dirty_reg[req_idx] <= 1'b0;
            end
            if (state_next == WRITEBACK) begin
                mem_wr_en  <= 1'b1;
                mem_addr   <= {line_tag, req_idx, {OFF_W{1'b0}}};
                mem_wr_blk <= line_data;
            end
            if (state_next == ALLOCATE) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
        end
    end

    // Line storage: merge one word on a write hit, or load the whole line on a refill.
    always_ff @(posedge clk) begin
        if (state_reg == COMPARE && line_hit && req_wr_reg) data_mem[req_idx] <= line_merged;
        if (state_reg == FILL) begin
            data_mem[req_idx] <= mem_rd_blk;
            tag_mem[req_idx]  <= req_tag;
        end
    end
endmodule

// File: tb/tb_cache_data_ctl.sv
`timescale 1ns/1ps
// Bench for cache_data_ctl.
// It runs a table of directed requests, a few hand-written multi-cycle sequences, and
// random requests. Results are compared with a list-level cache model.
// Latency is the number of rising edges from the request-sampling edge to the edge after
// which hit is seen. A hit takes 1 edge. A clean miss takes 4 edges:
// COMPARE, ALLOCATE, FILL, then COMPARE again. A dirty miss adds WRITEBACK, for 5 edges.
module tb_cache_data_ctl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  addr;
    logic [31:0]  data_wr;
    logic         rd_en, wr_en;
    logic [127:0] mem_rd_blk;
    logic [15:0]  mem_addr;
    logic         mem_rd_en, mem_wr_en;
    logic [127:0] mem_wr_blk;
    logic         hit;
    logic [31:0]  word_out;
    logic [7:0]   byte_out;

    always #5 clk = ~clk;

    cache_data_ctl dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_wr(data_wr),
        .rd_en(rd_en), .wr_en(wr_en), .mem_rd_blk(mem_rd_blk),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_blk(mem_wr_blk), .hit(hit), .word_out(word_out), .byte_out(byte_out)
    );

    typedef struct {
        logic [15:0]  a;
        logic         r;
        logic         w;
        logic [31:0]  d;
        int           lat;
        logic [31:0]  word;
        logic [7:0]   byt;
        int           n_rd;
        int           n_wr;
        logic [15:0]  rd_a;
        logic [15:0]  wr_a;
        logic [127:0] wb;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Initial content of memory block i. Blocks 1 and 0x11 have fixed values.
    function automatic logic [127:0] init_blk(input int i);
        logic [127:0] b;
        if (i == 1)         b = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        else if (i == 'h11) b = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
        else begin
            for (int k = 0; k < 4; k++)
                b[32*k +: 32] = 32'(i * 32'h9E3779B1) ^ 32'(k * 32'h01234567) ^ 32'h5A5A0000;
        end
        return b;
    endfunction

    // Backing memory partner. Writes commit on the strobe edge. Read data is registered.
    // The process also counts strobes and checks memory-port protocol.
    logic [127:0] mem_arr [256];
    logic [127:0] rd_q;
    logic [15:0]  last_rd_addr, last_wr_addr;
    logic [127:0] last_wr_blk;
    int mon_rd = 0, mon_wr = 0, mon_bad = 0;
    assign mem_rd_blk = rd_q;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = init_blk(i);
        rd_q = '0; last_rd_addr = '0; last_wr_addr = '0; last_wr_blk = '0;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b0) begin
                if (mem_rd_en) begin
                    rd_q <= mem_arr[mem_addr[15:4]];
                    last_rd_addr <= mem_addr;
                    mon_rd++;
                end
                if (mem_wr_en) begin
                    mem_arr[mem_addr[15:4]] <= mem_wr_blk;
                    last_wr_addr <= mem_addr;
                    last_wr_blk  <= mem_wr_blk;
                    mon_wr++;
                end
                if ((mem_rd_en || mem_wr_en) && mem_addr[3:0] != 4'h0) mon_bad++;
                if (mem_rd_en && mem_wr_en) mon_bad++;
                if (!mem_rd_en && !mem_wr_en && (mem_addr != 16'h0 || mem_wr_blk != '0)) mon_bad++;
            end
        end
    end

    // Reference model. It tracks line residency and contents, plus its own copy of memory.
    logic         ref_valid [16];
    logic         ref_dirty [16];
    logic [7:0]   ref_tag   [16];
    logic [127:0] ref_line  [16];
    logic [127:0] ref_mem   [256];

    task automatic model_req(input logic [15:0] a, input logic r, input logic w,
                             input logic [31:0] d, output vec_t e);
        int idx, wd;
        logic [7:0] tg;
        idx = int'(a[7:4]); wd = int'(a[3:2]); tg = a[15:8];
        e.a = a; e.r = r; e.w = w; e.d = d;
        e.n_rd = 0; e.n_wr = 0; e.rd_a = '0; e.wr_a = '0; e.wb = '0;
        if (ref_valid[idx] && ref_tag[idx] == tg) begin
            e.lat = 1;
        end else begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                e.n_wr = 1;
                e.wr_a = {ref_tag[idx], 4'(idx), 4'h0};
                e.wb   = ref_line[idx];
                ref_mem[{ref_tag[idx], 4'(idx)}] = ref_line[idx];
                e.lat  = 5;
            end else begin
                e.lat = 4;
            end
            e.n_rd = 1;
            e.rd_a = {tg, 4'(idx), 4'h0};
            ref_line[idx]  = ref_mem[{tg, 4'(idx)}];
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
            ref_tag[idx]   = tg;
        end
        if (w) begin
            ref_line[idx][32*wd +: 32] = d;
            ref_dirty[idx] = 1'b1;
            e.word = d;
        end else begin
            e.word = ref_line[idx][32*wd +: 32];
        end
        e.byt = 8'(e.word >> (8 * int'(a[1:0])));
    endtask

    task automatic chk(input string grp, input string what,
                       input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", grp, what, act, exp);
        end
    endtask

    // Present one request and hold it until hit. Then compare every observable result.
    // With scramble set, the strobes and inputs are corrupted while the DUT is busy.
    task automatic run_and_check(input string nm, input vec_t x, input bit scramble);
        int rd0, wr0, lat;
        logic [7:0] exp_byte;
        rd0 = mon_rd; wr0 = mon_wr;
        @(negedge clk);
        addr = x.a; rd_en = x.r; wr_en = x.w; data_wr = x.d;
        @(posedge clk);
        #1;
        if (scramble) begin
            addr = 16'($urandom); rd_en = 1'b1; wr_en = 1'b1; data_wr = $urandom;
        end
        lat = 0;
        while (!hit && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd_en = 1'b0; wr_en = 1'b0;
`ifdef CACHE_BYTE_OUT_EN
        exp_byte = x.byt;
`else
        exp_byte = 8'h00;
`endif
        chk(nm, "latency", lat, x.lat);
        chk(nm, "word_out", word_out, x.word);
        chk(nm, "byte_out", byte_out, exp_byte);
        chk(nm, "mem_rd_strobes", mon_rd - rd0, x.n_rd);
        chk(nm, "mem_wr_strobes", mon_wr - wr0, x.n_wr);
        if (x.n_rd > 0) chk(nm, "mem_rd_addr", last_rd_addr, x.rd_a);
        if (x.n_wr > 0) begin
            chk(nm, "mem_wr_addr", last_wr_addr, x.wr_a);
            chk(nm, "mem_wr_blk", last_wr_blk, x.wb);
        end
        @(posedge clk);
        #1;
        chk(nm, "hit_one_cycle", hit, 1'b0);
        chk(nm, "word_out_hold", word_out, x.word);
        $display("txn %s addr=%h rd=%0d wr=%0d data=%h lat=%0d word_out=%h byte_out=%h",
                 nm, x.a, x.r, x.w, x.d, lat, word_out, byte_out);
    endtask

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        bit seen;
        int k;
        logic [15:0] ra;

        // Directed table. Fields: addr, rd, wr, data, latency, word, byte,
        // rd strobes, wr strobes, rd addr, wr addr, written-back block.
        vecs[0] = '{16'h0010, 1, 0, 32'h0, 4, 32'h11111111, 8'h11, 1, 0, 16'h0010, 16'h0, 128'h0};
        vecs[1] = '{16'h001B, 1, 0, 32'h0, 1, 32'h33333333, 8'h33, 0, 0, 16'h0, 16'h0, 128'h0};
        vecs[2] = '{16'h0014, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 8'hEF, 0, 0, 16'h0, 16'h0, 128'h0};
        vecs[3] = '{16'h0015, 1, 0, 32'h0, 1, 32'hDEADBEEF, 8'hBE, 0, 0, 16'h0, 16'h0, 128'h0};
        vecs[4] = '{16'h0110, 1, 0, 32'h0, 5, 32'h55555555, 8'h55, 1, 1, 16'h0110, 16'h0010,
                    {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111}};
        vecs[5] = '{16'h0014, 1, 0, 32'h0, 4, 32'hDEADBEEF, 8'hEF, 1, 0, 16'h0010, 16'h0, 128'h0};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_blk(i);
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; ref_tag[i] = '0; ref_line[i] = '0;
        end

        rst_n = 1'b1; addr = '0; data_wr = '0; rd_en = 1'b0; wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", "ctl_outputs", {hit, word_out, byte_out, mem_addr, mem_rd_en, mem_wr_en}, '0);
        chk("reset", "mem_wr_blk", mem_wr_blk, '0);
        @(negedge clk);
        rst_n = 1'b0;

        for (int i = 0; i < 6; i++) begin
            model_req(vecs[i].a, vecs[i].r, vecs[i].w, vecs[i].d, e);
            run_and_check($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Assert reset while the DUT is in ALLOCATE. The victim line is invalid, so no
        // writeback has happened.
        @(negedge clk);
        addr = 16'h0230; rd_en = 1'b1; wr_en = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 10) begin
            @(posedge clk);
            #1;
            if (mem_rd_en) seen = 1'b1;
            k++;
        end
        chk("midrst", "allocate_reached", seen, 1'b1);
        #2 rst_n = 1'b1;
        #1;
        chk("midrst", "ctl_outputs", {hit, word_out, byte_out, mem_addr, mem_rd_en, mem_wr_en}, '0);
        chk("midrst", "mem_wr_blk", mem_wr_blk, '0);
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0;
        end

        // All lines are invalid after reset, so this read misses again.
        model_req(16'h0010, 1'b1, 1'b0, 32'h0, e);
        chk("postrst", "model_expects_miss", e.lat, 4);
        run_and_check("postrst_rd", e, 1'b0);

        // Both strobes high means the request is a write.
        model_req(16'h0018, 1'b1, 1'b1, 32'hA5A5A5A5, e);
        run_and_check("both_strobes", e, 1'b0);
        model_req(16'h0018, 1'b1, 1'b0, 32'h0, e);
        run_and_check("both_readback", e, 1'b0);

        // Dirty miss whose inputs are scrambled while the DUT is busy.
        model_req(16'h0310, 1'b1, 1'b0, 32'h0, e);
        run_and_check("busy_ignore", e, 1'b1);

        // Random requests over a small tag/index set, to force conflicts.
        for (int n = 0; n < 150; n++) begin
            logic r, w;
            k  = int'($urandom_range(0, 3));
            r  = (k != 2);
            w  = (k >= 2);
            ra = {8'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            model_req(ra, r, w, $urandom, e);
            run_and_check($sformatf("rnd%0d", n), e, ($urandom_range(0, 9) == 0));
        end

        chk("monitor", "mem_protocol_violations", mon_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
